// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: bus between the multicycle control sequencer and the datapath.
// The master side is the sequencer: it receives the decoded opcode, the ALU
// zero flag and the memory ready, and drives every load enable and select.
interface ctrl_seq_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       aluout_we;
    logic       mdr_we;
    logic       rf_we;
    logic       rf_src;
    logic [2:0] alu_op;
    logic       alu_srcb;
    logic       mem_rd;
    logic       mem_wr;
    logic       illegal;
    logic       halted;
    logic       bus_err;
    logic [2:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_we, pc_src, ir_we, aluout_we, mdr_we, rf_we, rf_src,
               alu_op, alu_srcb, mem_rd, mem_wr, illegal, halted, bus_err, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_we, pc_src, ir_we, aluout_we, mdr_we, rf_we, rf_src,
               alu_op, alu_srcb, mem_rd, mem_wr, illegal, halted, bus_err, state
    );
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: multicycle control sequencer for the 16-bit RISC datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. All control
// outputs are decoded from the state register (plus opcode, zero, mem_ready),
// so an asynchronous reset clears them without waiting for a clock edge.
// Optional feature macro: CTRL_MEM_TIMEOUT_EN -- bounds memory wait states to
// TIMEOUT cycles, then raises a sticky bus_err and parks in HALT. When the
// macro is undefined, waits are unbounded and bus_err is tied low.
module ctrl_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    ctrl_seq_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JMP  = 2'd2;

    // A zero timeout would make every memory access fail immediately.
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("ctrl_seq: TIMEOUT must be at least 1");
    end

    // Opcodes 0x0-0x6 are register-register ALU operations.
    function automatic logic is_rtype(input logic [3:0] op);
        return (op <= 4'h6);
    endfunction

    // Opcodes 0xC-0xE are undefined and retire as NOPs.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hC) && (op <= 4'hE);
    endfunction

    state_t     state_q;
    state_t     state_d;
    state_t     fsm_next_s;
    logic       timeout_s;

    logic       pc_we_s;
    logic [1:0] pc_src_s;
    logic       ir_we_s;
    logic       aluout_we_s;
    logic       mdr_we_s;
    logic       rf_we_s;
    logic       rf_src_s;
    logic [2:0] alu_op_s;
    logic       alu_srcb_s;
    logic       mem_rd_s;
    logic       mem_wr_s;
    logic       illegal_s;
    logic       halted_s;

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] wait_d;
    logic             bus_err_q;
    logic             bus_err_d;
    logic             waiting_s;

    // A wait cycle is a memory phase without ready; the TIMEOUT-th one aborts.
    assign waiting_s = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;
    assign timeout_s = waiting_s && (wait_q == CNT_W'(TIMEOUT - 1));
    assign bus_err_d = bus_err_q | timeout_s;

    // Wait counter: counts consecutive wait cycles, cleared on any other cycle
    // (which also covers every fresh entry into FETCH or MEM).
    always_comb begin
        wait_d = '0;
        if (waiting_s) begin
            wait_d = wait_q + CNT_W'(1);
        end else begin
            wait_d = '0;
        end
    end

    // Wait counter and sticky bus error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.bus_err = bus_err_q;
`else
    assign timeout_s   = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    // A memory timeout overrides the normal sequencing and parks the core.
    assign state_d = timeout_s ? ST_HALT : fsm_next_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; every enable defaults low.
    always_comb begin
        fsm_next_s  = state_q;
        pc_we_s     = 1'b0;
        pc_src_s    = PC_INC;
        ir_we_s     = 1'b0;
        aluout_we_s = 1'b0;
        mdr_we_s    = 1'b0;
        rf_we_s     = 1'b0;
        rf_src_s    = 1'b0;
        alu_op_s    = ALU_ADD;
        alu_srcb_s  = 1'b0;
        mem_rd_s    = 1'b0;
        mem_wr_s    = 1'b0;
        illegal_s   = 1'b0;
        halted_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                fsm_next_s = ST_FETCH;
            end

            ST_FETCH: begin
                mem_rd_s = 1'b1;
                if (bus.mem_ready) begin
                    ir_we_s    = 1'b1;
                    pc_we_s    = 1'b1;
                    pc_src_s   = PC_INC;
                    fsm_next_s = ST_DECODE;
                end else begin
                    fsm_next_s = ST_FETCH;
                end
            end

            ST_DECODE: begin
                if (bus.opcode == OP_HLT) begin
                    fsm_next_s = ST_HALT;
                end else if (bus.opcode == OP_JMP) begin
                    pc_we_s    = 1'b1;
                    pc_src_s   = PC_JMP;
                    fsm_next_s = ST_FETCH;
                end else if (is_illegal(bus.opcode)) begin
                    illegal_s  = 1'b1;
                    fsm_next_s = ST_FETCH;
                end else begin
                    fsm_next_s = ST_EXEC;
                end
            end

            ST_EXEC: begin
                aluout_we_s = 1'b1;
                if (is_rtype(bus.opcode)) begin
                    alu_op_s = bus.opcode[2:0];
                end else if (bus.opcode == OP_BEQ) begin
                    alu_op_s = ALU_SUB;
                end else begin
                    alu_op_s = ALU_ADD;
                end
                alu_srcb_s = (bus.opcode == OP_ADDI) || (bus.opcode == OP_LW) ||
                             (bus.opcode == OP_SW);

                if (bus.opcode == OP_BEQ) begin
                    if (bus.zero) begin
                        pc_we_s  = 1'b1;
                        pc_src_s = PC_BR;
                    end else begin
                        pc_we_s  = 1'b0;
                    end
                    fsm_next_s = ST_FETCH;
                end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
                    fsm_next_s = ST_MEM;
                end else if (is_rtype(bus.opcode) || (bus.opcode == OP_ADDI)) begin
                    fsm_next_s = ST_WB;
                end else begin
                    // Opcodes that never reach EXEC fall back to the next fetch.
                    fsm_next_s = ST_FETCH;
                end
            end

            ST_MEM: begin
                case (bus.opcode)
                    OP_LW: begin
                        mem_rd_s = 1'b1;
                        if (bus.mem_ready) begin
                            mdr_we_s   = 1'b1;
                            fsm_next_s = ST_WB;
                        end else begin
                            fsm_next_s = ST_MEM;
                        end
                    end
                    OP_SW: begin
                        mem_wr_s = 1'b1;
                        if (bus.mem_ready) begin
                            fsm_next_s = ST_FETCH;
                        end else begin
                            fsm_next_s = ST_MEM;
                        end
                    end
                    default: begin
                        fsm_next_s = ST_FETCH;
                    end
                endcase
            end

            ST_WB: begin
                rf_we_s    = 1'b1;
                rf_src_s   = (bus.opcode == OP_LW);
                fsm_next_s = ST_FETCH;
            end

            ST_HALT: begin
                halted_s   = 1'b1;
                fsm_next_s = ST_HALT;
            end

            default: begin
                fsm_next_s = ST_IDLE;
            end
        endcase
    end

    assign bus.pc_we     = pc_we_s;
    assign bus.pc_src    = pc_src_s;
    assign bus.ir_we     = ir_we_s;
    assign bus.aluout_we = aluout_we_s;
    assign bus.mdr_we    = mdr_we_s;
    assign bus.rf_we     = rf_we_s;
    assign bus.rf_src    = rf_src_s;
    assign bus.alu_op    = alu_op_s;
    assign bus.alu_srcb  = alu_srcb_s;
    assign bus.mem_rd    = mem_rd_s;
    assign bus.mem_wr    = mem_wr_s;
    assign bus.illegal   = illegal_s;
    assign bus.halted    = halted_s;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: scoreboard bench for ctrl_seq. Each instruction is expanded
// into a per-cycle list of expected control vectors and input stimulus; the
// runner drives one stimulus per cycle and compares the DUT against the
// matching expected vector.
module tb_ctrl_seq;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       aluout_we;
        logic       mdr_we;
        logic       rf_we;
        logic       rf_src;
        logic [2:0] alu_op;
        logic       alu_srcb;
        logic       mem_rd;
        logic       mem_wr;
        logic       illegal;
        logic       halted;
        logic       bus_err;
    } vec_t;

    typedef struct packed {
        logic       rdy;
        logic [3:0] op;
        logic       z;
    } stim_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    vec_t  exp_q[$];
    stim_t stim_q[$];
    int    compared = 0;
    int    mismatched = 0;
    int    cyc = 0;

    always #5 clk = ~clk;

    ctrl_seq_if bus ();

    ctrl_seq #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic rnd();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic vec_t sample();
        vec_t a;
        a.st        = bus.state;
        a.pc_we     = bus.pc_we;
        a.pc_src    = bus.pc_src;
        a.ir_we     = bus.ir_we;
        a.aluout_we = bus.aluout_we;
        a.mdr_we    = bus.mdr_we;
        a.rf_we     = bus.rf_we;
        a.rf_src    = bus.rf_src;
        a.alu_op    = bus.alu_op;
        a.alu_srcb  = bus.alu_srcb;
        a.mem_rd    = bus.mem_rd;
        a.mem_wr    = bus.mem_wr;
        a.illegal   = bus.illegal;
        a.halted    = bus.halted;
        a.bus_err   = bus.bus_err;
        return a;
    endfunction

    task automatic push(input vec_t e, input logic rdy, input logic [3:0] op, input logic z);
        stim_t s;
        s.rdy = rdy;
        s.op  = op;
        s.z   = z;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Expected cycle sequence of one instruction; fw/mw are wait cycles in FETCH/MEM.
    task automatic add_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
        vec_t e;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.st = 3'd1; e.mem_rd = 1'b1;
            push(e, 1'b0, op, z);
        end
        e = '0; e.st = 3'd1; e.mem_rd = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.pc_src = 2'd0;
        push(e, 1'b1, op, z);
        e = '0; e.st = 3'd2;
        if (op == 4'hB) begin
            e.pc_we = 1'b1; e.pc_src = 2'd2;
        end else if (op >= 4'hC && op <= 4'hE) begin
            e.illegal = 1'b1;
        end
        push(e, rnd(), op, z);
        if (op >= 4'hB) return;
        e = '0; e.st = 3'd3; e.aluout_we = 1'b1;
        if (op <= 4'h6)       e.alu_op = op[2:0];
        else if (op == 4'hA)  e.alu_op = 3'd1;
        else                  e.alu_op = 3'd0;
        e.alu_srcb = (op == 4'h7) || (op == 4'h8) || (op == 4'h9);
        if (op == 4'hA && z) begin
            e.pc_we = 1'b1; e.pc_src = 2'd1;
        end
        push(e, rnd(), op, z);
        if (op == 4'hA) return;
        if (op == 4'h8 || op == 4'h9) begin
            e = '0; e.st = 3'd4; e.mem_rd = (op == 4'h8); e.mem_wr = (op == 4'h9);
            for (int i = 0; i < mw; i++) push(e, 1'b0, op, z);
            e.mdr_we = (op == 4'h8);
            push(e, 1'b1, op, z);
            if (op == 4'h9) return;
        end
        e = '0; e.st = 3'd5; e.rf_we = 1'b1; e.rf_src = (op == 4'h8);
        push(e, rnd(), op, z);
    endtask

    task automatic add_halt(input int n, input logic err);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            e = '0; e.st = 3'd6; e.halted = 1'b1; e.bus_err = err;
            push(e, rnd(), 4'($urandom_range(15, 0)), rnd());
        end
    endtask

    // Drives queued stimulus (n entries, or all when n < 0) and scores each cycle.
    task automatic run_queue(input string tag, input int n);
        int k;
        k = 0;
        while (stim_q.size() > 0 && (n < 0 || k < n)) begin
            stim_t s;
            vec_t  e;
            vec_t  a;
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            bus.mem_ready = s.rdy;
            bus.opcode    = s.op;
            bus.zero      = s.z;
            #2;
            a = sample();
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, a, e);
            end
            cyc++;
            k++;
        end
    endtask

    // Releases reset just after a rising edge, so the next sample is the IDLE cycle.
    task automatic release_reset();
        vec_t e;
        @(posedge clk);
        #1 rst_n = 1'b1;
        e = '0;
        push(e, rnd(), 4'h0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        vec_t a;
        a = sample();
        compared++;
        if (a !== vec_t'(0)) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, a, vec_t'(0));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            bus.opcode    = 4'($urandom_range(15, 0));
            bus.zero      = rnd();
            #2;
            check_all_zero("reset_hold");
        end
        release_reset();
        add_instr(4'h0, 1'b0, 0, 0);
        run_queue("rtype_add", -1);
    endtask

    task automatic test_lw_wait();
        add_instr(4'h8, 1'b0, 0, 2);
        run_queue("lw_wait", -1);
    endtask

    task automatic test_beq();
        add_instr(4'hA, 1'b1, 0, 0);
        add_instr(4'hA, 1'b0, 0, 0);
        run_queue("beq", -1);
    endtask

    task automatic test_back_to_back();
        add_instr(4'h7, 1'b0, 1, 0);
        for (int op = 1; op <= 6; op++) begin
            add_instr(4'(op), rnd(), $urandom_range(2, 0), 0);
        end
        add_instr(4'h9, 1'b0, 0, 1);
        add_instr(4'hB, 1'b0, 0, 0);
        add_instr(4'h8, 1'b1, 1, 0);
        add_instr(4'hA, 1'b1, 2, 0);
        run_queue("back_to_back", -1);
    endtask

    task automatic test_long_wait();
        add_instr(4'h9, 1'b0, 20, 20);
        run_queue("long_wait", -1);
    endtask

    task automatic test_illegal_halt();
        add_instr(4'hD, 1'b0, 0, 0);
        add_instr(4'hF, 1'b0, 0, 0);
        add_halt(6, 1'b0);
        run_queue("illegal_halt", -1);
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.halted !== 1'b0 || bus.state !== 3'd0) begin
            mismatched++;
            $display("FAIL halt_reset: got halted=%b state=%0d expected halted=0 state=0",
                     bus.halted, bus.state);
        end
        release_reset();
    endtask

    task automatic test_reset_mid_sw();
        add_instr(4'h9, 1'b0, 0, 3);
        run_queue("sw_pre_reset", 5);
        stim_q.delete();
        exp_q.delete();
        compared++;
        if (bus.mem_wr !== 1'b1) begin
            mismatched++;
            $display("FAIL sw_mem_wr: got %b expected 1", bus.mem_wr);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.mem_wr !== 1'b0) begin
            mismatched++;
            $display("FAIL sw_reset_mem_wr: got %b expected 0", bus.mem_wr);
        end
        check_all_zero("sw_reset_all");
        release_reset();
    endtask

    task automatic test_timeout();
        vec_t e;
        for (int i = 0; i < 15; i++) begin
            e = '0; e.st = 3'd1; e.mem_rd = 1'b1;
            push(e, 1'b0, 4'h0, 1'b0);
        end
        add_halt(4, 1'b1);
        run_queue("timeout", -1);
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.opcode    = 4'h0;
        bus.zero      = 1'b0;
        test_reset();
        test_lw_wait();
        test_beq();
        test_back_to_back();
`ifndef CTRL_MEM_TIMEOUT_EN
        test_long_wait();
`endif
        test_illegal_halt();
        test_reset_mid_sw();
`ifdef CTRL_MEM_TIMEOUT_EN
        test_timeout();
`else
        add_instr(4'h3, 1'b0, 0, 0);
        run_queue("after_reset", -1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Multicycle control sequencer for the 16-bit RISC datapath. A Moore-style FSM steps each instruction through fetch, decode, execute, memory and write-back phases. It drives the load enables of the PC, instruction register, ALU result register, memory data register and register file, plus the ALU function and mux selects. Memory accesses use a ready handshake, so instruction and data memories may insert wait states.

## Interface
- `TIMEOUT`, default 15: maximum number of wait cycles on `mem_ready` before a bus error. Used only with `CTRL_MEM_TIMEOUT_EN`.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `opcode`, input, 4: `instr[15:12]` from the instruction register; valid from DECODE onward.
- `zero`, input, 1: ALU zero flag; sampled in EXEC.
- `mem_ready`, input, 1: memory completes the current read or write this cycle.
- `pc_we`, output, 1: PC load enable.
- `pc_src`, output, 2: PC source select. 0 = PC+1, 1 = branch target, 2 = jump target.
- `ir_we`, output, 1: instruction register load.
- `aluout_we`, output, 1: ALU result register load.
- `mdr_we`, output, 1: memory data register load.
- `rf_we`, output, 1: register file write.
- `rf_src`, output, 1: register file write source. 0 = ALU result register, 1 = memory data register.
- `alu_op`, output, 3: ALU function. 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr.
- `alu_srcb`, output, 1: ALU operand B select. 0 = register, 1 = sign-extended immediate.
- `mem_rd`, output, 1: memory read request.
- `mem_wr`, output, 1: memory write request.
- `illegal`, output, 1: one-cycle pulse when an undefined opcode is decoded.
- `halted`, output, 1: processor stopped.
- `bus_err`, output, 1: sticky memory timeout flag.
- `state`, output, 3: current state, for debug.

## Operation
- Opcode map:
  - 0x0–0x6: R-type. `alu_op` = `opcode[2:0]`.
  - 0x7: ADDI.
  - 0x8: LW.
  - 0x9: SW.
  - 0xA: BEQ.
  - 0xB: JMP.
  - 0xF: HLT.
  - 0xC–0xE: illegal.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE:
  - All outputs 0.
  - Always moves to FETCH next cycle.
- FETCH:
  - `mem_rd` held at 1.
  - In the cycle `mem_ready` is 1: `ir_we`=1 and `pc_we`=1 with `pc_src`=0, then move to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - HLT → HALT.
  - JMP: `pc_we`=1, `pc_src`=2 → FETCH.
  - Illegal opcode: `illegal`=1 → FETCH. Treated as a NOP.
  - All other opcodes → EXEC.
- EXEC: `aluout_we`=1.
  - `alu_op`: `opcode[2:0]` for R-type; add for ADDI, LW and SW; sub for BEQ.
  - `alu_srcb`: 1 for ADDI, LW and SW; 0 otherwise.
  - BEQ: if `zero`=1, `pc_we`=1 with `pc_src`=1. BEQ then goes to FETCH.
  - LW and SW → MEM. R-type and ADDI → WB.
- MEM:
  - LW: `mem_rd`=1. On `mem_ready`, `mdr_we`=1 → WB.
  - SW: `mem_wr`=1. On `mem_ready` → FETCH.
  - Without `mem_ready`, stay in MEM.
- WB: `rf_we`=1, `rf_src` = 1 for LW and 0 otherwise → FETCH.
- HALT:
  - `halted`=1, all enables 0.
  - Left only by reset.
- Outputs are decoded from `state`, `opcode`, `zero` and `mem_ready`. Any enable not listed for a state is 0.

## Timing
- While `rst_n`=0:
  - `state` = IDLE.
  - Every output is 0, including `bus_err`, `halted` and `illegal`.
- First fetch request appears one cycle after `rst_n` rises.
- Instruction latency in cycles, zero-wait memory:
  - R-type and ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ: 3.
  - JMP: 2.
  - HLT: 2, reaching HALT.
- Each wait cycle (`mem_ready`=0 during FETCH or MEM) adds one cycle.
- The memory must not see `mem_rd` and `mem_wr` both high; the controller never asserts both.
- A write enable is asserted for exactly one cycle per architectural update.
- `mem_ready` asserted outside FETCH or MEM is ignored.
- Reset asserted mid-instruction aborts it immediately: no further enables, state returns to IDLE.

## Configuration
- `CTRL_MEM_TIMEOUT_EN` defined:
  - A 4-bit-minimum wait counter clears on every FETCH or MEM entry and on every `mem_ready`.
  - It increments on each wait cycle.
  - When it reaches `TIMEOUT`, `bus_err` is set (sticky) and the next state is HALT; no enable fires.
- `CTRL_MEM_TIMEOUT_EN` undefined:
  - No counter.
  - Wait states are unbounded.
  - `bus_err` is tied to 0.

## Test plan
- Reset, then opcode 0x0 with `mem_ready`=1 constantly. Required: states 0,1,2,3,5,1. `ir_we`, `aluout_we` and `rf_we` each pulse once. `alu_op`=0.
- LW (0x8) with 2 wait cycles in MEM. Required: `mem_rd` high for 3 MEM cycles. `mdr_we` high only in the third. WB has `rf_src`=1. Total 7 cycles.
- BEQ (0xA) with `zero`=1, then `zero`=0. Required: first case `pc_we`=1 and `pc_src`=1 in EXEC. Second case no `pc_we` in EXEC. Both return to FETCH after 3 cycles.
- Opcode 0xD, then 0xF. Required: `illegal` pulses for 1 cycle in DECODE. Then HALT with `halted`=1 held until `rst_n` falls.
- Assert `rst_n`=0 during MEM of SW. Required: `mem_wr` drops asynchronously. `state`=0. All outputs 0.
- With `CTRL_MEM_TIMEOUT_EN` and `TIMEOUT`=15, `mem_ready`=0 in FETCH. Required: after 15 wait cycles `bus_err`=1, state HALT, `ir_we` never asserted.
